// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite / APB bridge definitions: bus width, APB arbiter states and
// the default ACCESS timeout used when APB_MASTER_ARB_TIMEOUT_EN is defined.
package ahb3lite_pkg;

  localparam int PDATA_SIZE = 32;

  localparam int APB_ARB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Returns a one-hot grant and its index; grant is all-zero when req is idle.
module apb_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  int idx;

  // Scan from the farthest offset down so the one closest to ptr wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Optional ACCESS timeout is enabled by defining APB_MASTER_ARB_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | no transfer; arbitrate pending requests
//   SETUP  | PSEL high, PENABLE low, exactly one cycle
//   ACCESS | PSEL and PENABLE high, waiting on PREADY (or timeout)
module apb_master_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = APB_ARB_TIMEOUT_CYCLES
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*PDATA_SIZE-1:0]   req_addr,
  input  logic [NREQ*PDATA_SIZE-1:0]   req_wdata,
  input  logic [NREQ*PDATA_SIZE/8-1:0] req_strb,
  input  logic [NREQ*3-1:0]            req_prot,
  output logic [NREQ-1:0]              ack,
  output logic [PDATA_SIZE-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [PDATA_SIZE-1:0]        PADDR,
  output logic [PDATA_SIZE-1:0]        PWDATA,
  output logic [PDATA_SIZE/8-1:0]      PSTRB,
  output logic [2:0]                   PPROT,
  input  logic [PDATA_SIZE-1:0]        PRDATA,
  input  logic                         PREADY,
  input  logic                         PSLVERR
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = PDATA_SIZE / 8;

  if (NREQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_arbiter: NREQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  apb_arb_state_t  state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NREQ-1:0] gone_q, gone_d, ack_q, ack_d;
  logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [PDATA_SIZE-1:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [PDATA_SIZE-1:0] rdata_q, rdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [2:0]      pprot_q, pprot_d;
  logic            err_q, err_d, busy_q, busy_d;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            tmo;

  apb_rr_picker #(.NREQ(NREQ)) u_picker (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

`ifdef APB_MASTER_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmr_q, tmr_d;

  // Down-counter loaded in SETUP; terminal count in ACCESS means the wait expired.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == SETUP) tmr_d = TW'(TIMEOUT_CYCLES - 1);
    else if (state_q == ACCESS && !PREADY && tmr_q != '0) tmr_d = tmr_q - TW'(1);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign tmo = (tmr_q == '0);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    gone_d    = gone_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    ack_d     = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gidx_d    = pick_idx;
          gone_d    = pick_grant;
          pwrite_d  = req_write[pick_idx];
          paddr_d   = req_addr[pick_idx*PDATA_SIZE +: PDATA_SIZE];
          pwdata_d  = req_wdata[pick_idx*PDATA_SIZE +: PDATA_SIZE];
          pstrb_d   = req_write[pick_idx] ? req_strb[pick_idx*SW +: SW] : '0;
          pprot_d   = req_prot[pick_idx*3 +: 3];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || tmo) begin
          ack_d     = gone_q;
          rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
          err_d     = PREADY ? PSLVERR : 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ptr_d     = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gone_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gone_q    <= gone_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;
  assign ack       = ack_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;

endmodule
